// File: rtl/adder_stream_arbiter_pkg.sv
// Shared types for the adder stream arbiter.
// The optional ADDER_ARB_CARRY_OUT_EN macro adds res_carry to the core and the top.
package adder_stream_arbiter_pkg;

    localparam int WORD_SIZE = 8;
    localparam int MAX_REQ   = 16;

    typedef logic [WORD_SIZE-1:0]        wordType;
    typedef logic [$clog2(MAX_REQ)-1:0]  reqIdType;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/adder_stream_arbiter_word_serial_add_core.sv
// Word-serial adder: carry chain across the beats of a packet plus registered result word.
// With ADDER_ARB_CARRY_OUT_EN defined it also exposes the carry out of each beat.
module word_serial_add_core
    import adder_stream_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    beat,
    input  logic    last,
    input  wordType a,
    input  wordType b,
    output logic    res_valid,
    output logic    res_last,
    output wordType res_data
`ifdef ADDER_ARB_CARRY_OUT_EN
    ,
    output logic    res_carry
`endif
);

    logic               carry;
    logic [WORD_SIZE:0] sum;

    assign sum = {1'b0, a} + {1'b0, b} + {{WORD_SIZE{1'b0}}, carry};

    // Carry survives bubbles because it only moves on beats; the last beat clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry     <= 1'b0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            res_data  <= '0;
`ifdef ADDER_ARB_CARRY_OUT_EN
            res_carry <= 1'b0;
`endif
        end else begin
            res_valid <= beat;
            res_last  <= beat & last;
            if (beat) begin
                res_data <= sum[WORD_SIZE-1:0];
                carry    <= last ? 1'b0 : sum[WORD_SIZE];
`ifdef ADDER_ARB_CARRY_OUT_EN
                res_carry <= sum[WORD_SIZE];
`endif
            end
        end
    end

endmodule

// File: rtl/adder_stream_arbiter.sv
// Round-robin arbiter sharing one word-serial adder between NUM_REQ operand streams.
// ADDER_ARB_CARRY_OUT_EN adds the res_carry output (full-width sum carry).
//
// state | meaning
// IDLE  | no packet owns the adder; pick next requester from rr_ptr
// BUSY  | grant locked to one requester until its last beat
module adder_stream_arbiter
    import adder_stream_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*WORD_SIZE-1:0] req_data_0,
    input  logic [NUM_REQ*WORD_SIZE-1:0] req_data_1,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         res_valid,
    output logic                         res_last,
    output logic [WORD_SIZE-1:0]         res_data,
    output logic [$clog2(NUM_REQ)-1:0]   res_id,
    output logic                         busy
`ifdef ADDER_ARB_CARRY_OUT_EN
    ,
    output logic                         res_carry
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_BUSY = BUSY;

    logic [0:0]      state;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] rr_ptr;
    logic            pick_found;
    reqIdType        pick_id;
    int              cand;
    logic            beat;
    logic            last_beat;
    wordType         op_a;
    wordType         op_b;

    // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!pick_found && req_valid[ID_W'(cand)]) begin
                pick_found = 1'b1;
                pick_id    = reqIdType'(cand);
            end
        end
    end

    assign beat      = (state == ST_BUSY) & req_valid[grant] & req_ready[grant];
    assign last_beat = beat & req_last[grant];
    assign op_a      = req_data_0[int'(grant)*WORD_SIZE +: WORD_SIZE];
    assign op_b      = req_data_1[int'(grant)*WORD_SIZE +: WORD_SIZE];
    assign busy      = (state == ST_BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            req_ready <= '0;
            res_id    <= '0;
        end else begin
            if (beat) begin
                res_id <= grant;
            end
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant     <= ID_W'(pick_id);
                        req_ready <= NUM_REQ'(1) << pick_id;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (last_beat) begin
                        state     <= ST_IDLE;
                        req_ready <= '0;
                        rr_ptr    <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= '0;
                end
            endcase
        end
    end

    word_serial_add_core u_core (
        .clk       (clk),
        .rst       (rst),
        .beat      (beat),
        .last      (last_beat),
        .a         (op_a),
        .b         (op_b),
        .res_valid (res_valid),
        .res_last  (res_last),
        .res_data  (res_data)
`ifdef ADDER_ARB_CARRY_OUT_EN
        ,
        .res_carry (res_carry)
`endif
    );

endmodule

// File: tb/tb_adder_stream_arbiter.sv
// Bench for adder_stream_arbiter: directed vector table, reset/bubble/contention sequences
// and randomized multi-requester traffic checked against a packet-level sum model.
module tb_adder_stream_arbiter;

    localparam int NUM_REQ = 4;
    localparam int W       = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_last;
    logic [NUM_REQ*W-1:0]   req_data_0;
    logic [NUM_REQ*W-1:0]   req_data_1;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   res_valid;
    logic                   res_last;
    logic [W-1:0]           res_data;
    logic [1:0]             res_id;
    logic                   busy;
`ifdef ADDER_ARB_CARRY_OUT_EN
    logic                   res_carry;
`endif

    always #5 clk = ~clk;

    adder_stream_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data_0 (req_data_0),
        .req_data_1 (req_data_1),
        .req_ready  (req_ready),
        .res_valid  (res_valid),
        .res_last   (res_last),
        .res_data   (res_data),
        .res_id     (res_id),
        .busy       (busy)
`ifdef ADDER_ARB_CARRY_OUT_EN
        ,
        .res_carry  (res_carry)
`endif
    );

    typedef struct { int len; logic [31:0] a; logic [31:0] b; int bub; } pkt_t;
    typedef struct { logic [7:0] data; logic last; int id; logic carry; } res_t;
    typedef struct { int id; int len; logic [31:0] a; logic [31:0] b; logic [31:0] sum; logic carry; } vec_t;

    pkt_t pq[NUM_REQ][$];
    res_t exp_res[$];
    res_t got_q[$];
    int   exp_grant[$];
    int   checks = 0;
    int   failures = 0;
    int   bubble_pct = 0;
    int   model_ptr = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
        end
    endtask

    // Packet-level model: round-robin order over queued packets, each packet an independent sum.
    task automatic build_expectations();
        int left[NUM_REQ];
        int nxt[NUM_REQ];
        int total = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            left[i] = pq[i].size();
            nxt[i]  = 0;
            total  += left[i];
        end
        while (total > 0) begin
            int g = -1;
            pkt_t p;
            logic [63:0] mask;
            logic [63:0] s;
            for (int k = 0; k < NUM_REQ; k++) begin
                int c = (model_ptr + k) % NUM_REQ;
                if (g < 0 && left[c] > 0) g = c;
            end
            p = pq[g][nxt[g]];
            exp_grant.push_back(g);
            mask = (64'd1 << (8 * p.len)) - 64'd1;
            s = ({32'd0, p.a} & mask) + ({32'd0, p.b} & mask);
            for (int w = 0; w < p.len; w++) begin
                res_t r;
                r.data  = s[8*w +: 8];
                r.last  = (w == p.len - 1);
                r.id    = g;
                r.carry = s[8*p.len];
                exp_res.push_back(r);
            end
            nxt[g]++;
            left[g]--;
            total--;
            model_ptr = (g + 1) % NUM_REQ;
        end
    endtask

    task automatic run_all(input int max_cycles);
        int cur_word[NUM_REQ];
        int cur_bub[NUM_REQ];
        logic [NUM_REQ-1:0] hs_pend = '0;
        logic [NUM_REQ-1:0] hs_last_pend = '0;
        logic [NUM_REQ-1:0] prev_ready;
        logic [NUM_REQ-1:0] hs;
        logic [NUM_REQ-1:0] hs_last;
        logic gap_due = 1'b0;
        int   cycles = 0;
        bit   work;
        for (int i = 0; i < NUM_REQ; i++) begin
            cur_word[i] = 0;
            cur_bub[i]  = 0;
        end
        prev_ready = req_ready;
        while (1) begin
            work = (exp_res.size() > 0);
            for (int i = 0; i < NUM_REQ; i++) if (pq[i].size() > 0) work = 1;
            if (!work && hs_pend == 0) break;
            if (cycles >= max_cycles) begin
                checks++;
                failures++;
                $display("FAIL run_timeout: %0d results still expected after %0d cycles", exp_res.size(), cycles);
                break;
            end
            @(negedge clk);
            cycles++;
            hs      = hs_pend;
            hs_last = hs_last_pend;
            chk("res_valid_latency", res_valid, hs != 0);
            chk("busy_vs_ready", busy, req_ready != 0);
            if (res_valid) begin
                if (exp_res.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_result: id %0d data 0x%0h, expected none", res_id, res_data);
                end else begin
                    res_t e;
                    res_t g;
                    e = exp_res.pop_front();
                    chk("res_data", res_data, e.data);
                    chk("res_last", res_last, e.last);
                    chk("res_id", res_id, e.id);
`ifdef ADDER_ARB_CARRY_OUT_EN
                    if (e.last) chk("res_carry", res_carry, e.carry);
                    g.carry = res_carry;
`else
                    g.carry = 1'b0;
`endif
                    g.data = res_data;
                    g.last = res_last;
                    g.id   = res_id;
                    got_q.push_back(g);
                end
            end
            if (hs_last != 0) chk("gap_ready_low", req_ready, 0);
            else if (gap_due) chk("gap_regrant", req_ready != 0, 1);
            if (prev_ready == 0 && req_ready != 0) begin
                if (exp_grant.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_grant: ready 0x%0h, expected no grant", req_ready);
                end else begin
                    chk("grant_order", req_ready, 64'd1 << exp_grant.pop_front());
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hs[i] && pq[i].size() > 0) begin
                    cur_word[i]++;
                    if (cur_word[i] == pq[i][0].len) begin
                        pq[i].delete(0);
                        cur_word[i] = 0;
                        cur_bub[i]  = 0;
                    end else if (cur_word[i] == 1) begin
                        cur_bub[i] = pq[i][0].bub;
                    end
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pq[i].size() > 0) begin
                    pkt_t p;
                    bit bub;
                    p = pq[i][0];
                    bub = 0;
                    if (cur_bub[i] > 0) begin
                        bub = 1;
                        cur_bub[i]--;
                    end else if (cur_word[i] > 0 && bubble_pct > 0 && $urandom_range(99) < bubble_pct) begin
                        bub = 1;
                    end
                    req_valid[i] = !bub;
                    req_last[i]  = (cur_word[i] == p.len - 1);
                    req_data_0[i*W +: W] = p.a[8*cur_word[i] +: 8];
                    req_data_1[i*W +: W] = p.b[8*cur_word[i] +: 8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
            gap_due      = (hs_last != 0) && (req_valid != 0);
            hs_pend      = req_valid & req_ready;
            hs_last_pend = hs_pend & req_last;
            prev_ready   = req_ready;
        end
        chk("grants_consumed", exp_grant.size(), 0);
        req_valid = '0;
        req_last  = '0;
        exp_res.delete();
        exp_grant.delete();
        for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        model_ptr = 0;
    endtask

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt[NUM_REQ];
        int n;
        logic [31:0] s;

        vecs[0] = '{0, 4, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0};
        vecs[1] = '{3, 1, 32'h000000FF, 32'h000000FF, 32'h000000FE, 1'b1};
        vecs[2] = '{3, 1, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0};
        vecs[3] = '{1, 2, 32'h0000FFFF, 32'h00000001, 32'h00000000, 1'b1};
        vecs[4] = '{2, 3, 32'h00123456, 32'h00654321, 32'h00777777, 1'b0};
        vecs[5] = '{0, 4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1};
        vecs[6] = '{2, 2, 32'h000080FF, 32'h00007F01, 32'h00000000, 1'b1};
        vecs[7] = '{1, 3, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0};

        rst        = 1'b1;
        req_valid  = '0;
        req_last   = '0;
        req_data_0 = '0;
        req_data_1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_last", res_last, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_busy", busy, 0);
`ifdef ADDER_ARB_CARRY_OUT_EN
        chk("rst_res_carry", res_carry, 0);
`endif
        rst = 1'b0;

        foreach (vecs[v]) begin
            pkt_t p;
            p = '{len: vecs[v].len, a: vecs[v].a, b: vecs[v].b, bub: 0};
            pq[vecs[v].id].push_back(p);
            build_expectations();
            got_q.delete();
            run_all(100);
            s = '0;
            for (int k = 0; k < got_q.size() && k < 4; k++) s[8*k +: 8] = got_q[k].data;
            chk("vec_words", got_q.size(), vecs[v].len);
            chk("vec_sum", s, vecs[v].sum);
`ifdef ADDER_ARB_CARRY_OUT_EN
            if (got_q.size() > 0) chk("vec_carry", got_q[got_q.size()-1].carry, vecs[v].carry);
`endif
        end

        // Reset after two of four beats, with a carry pending into word 2.
        do_reset();
        req_valid = 4'b0100;
        req_last  = '0;
        req_data_0[2*W +: W] = 8'hFF;
        req_data_1[2*W +: W] = 8'h01;
        n = 0;
        while (!req_ready[2] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rst_seq_grant", req_ready, 4'b0100);
        @(negedge clk);
        chk("rst_seq_w0", res_data, 8'h00);
        req_data_0[2*W +: W] = 8'hFF;
        req_data_1[2*W +: W] = 8'h00;
        @(negedge clk);
        chk("rst_seq_w1_valid", res_valid, 1);
        chk("rst_seq_w1", res_data, 8'h00);
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_res_data", res_data, 0);
        chk("midrst_res_last", res_last, 0);
        chk("midrst_res_id", res_id, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", req_ready, 0);
        rst       = 1'b0;
        model_ptr = 0;
        pq[2].push_back('{len: 4, a: 32'hFFFFFFFF, b: 32'h00000001, bub: 0});
        build_expectations();
        got_q.delete();
        run_all(100);
        chk("resend_words", got_q.size(), 4);

        // Three bubbles after word 1 while a carry is pending.
        pq[1].push_back('{len: 2, a: 32'h000001FF, b: 32'h00000001, bub: 3});
        build_expectations();
        got_q.delete();
        run_all(100);
        chk("bubble_words", got_q.size(), 2);
        if (got_q.size() == 2) chk("bubble_word2", got_q[1].data, 8'h02);

        // Contention between 1 and 2 from pointer 0.
        do_reset();
        pq[1].push_back('{len: 2, a: 32'h00001111, b: 32'h00002222, bub: 0});
        pq[1].push_back('{len: 1, a: 32'h00000005, b: 32'h00000006, bub: 0});
        pq[2].push_back('{len: 3, a: 32'h00ABCDEF, b: 32'h00010101, bub: 0});
        build_expectations();
        got_q.delete();
        run_all(200);
        chk("contend_first_id", got_q.size() > 0 ? got_q[0].id : -1, 1);
        chk("contend_second_id", got_q.size() > 2 ? got_q[2].id : -1, 2);

        // All requesters continuously valid, 16 two-word packets, random bubbles.
        do_reset();
        bubble_pct = 30;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < 4; k++) begin
                pkt_t p;
                p.len = 2;
                p.a   = $urandom();
                p.b   = $urandom();
                p.bub = 0;
                pq[i].push_back(p);
            end
        end
        build_expectations();
        got_q.delete();
        run_all(2000);
        for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
        foreach (got_q[k]) if (got_q[k].last) cnt[got_q[k].id]++;
        for (int i = 0; i < NUM_REQ; i++) chk($sformatf("per_id_count_%0d", i), cnt[i], 4);

        // Mixed random lengths, counts and forced bubbles.
        bubble_pct = 20;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                int np = $urandom_range(3);
                for (int k = 0; k < np; k++) begin
                    pkt_t p;
                    p.len = $urandom_range(4, 1);
                    p.a   = $urandom();
                    p.b   = $urandom();
                    p.bub = $urandom_range(2);
                    pq[i].push_back(p);
                end
            end
            build_expectations();
            got_q.delete();
            run_all(3000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
